rr_mux2_stream: RTL and testbench
=================================

# rr_mux2_stream

Two-channel round-robin stream arbiter that sits directly upstream of the 2:1 data mux and drives its select line. It buffers one word per input channel, picks between them fairly, and presents a registered, handshaked output stream tagged with its source channel. Turns the free-running select of the plain mux into flow-controlled, fair time-division sharing of one output path.

## Interface
- WIDTH, 8, data word width (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; one clock domain
- in0_data  in  WIDTH  channel 0 word
- in0_valid  in  1  channel 0 word present
- in0_ready  out  1  channel 0 holding register empty
- in1_data  in  WIDTH  channel 1 word
- in1_valid  in  1  channel 1 word present
- in1_ready  out  1  channel 1 holding register empty
- out_data  out  WIDTH  registered output word
- out_valid  out  1  out_data/out_src valid
- out_ready  in  1  downstream accepts
- out_src  out  1  channel that produced out_data (0/1)
- sel  out  1  combinational grant this cycle, drives 2:1 mux select (1 = channel 1)

## Operation
- Per channel: 1-entry holding register (hold_vN, hold_dN). inN_ready = ~hold_vN (registered state only, no combinational path from out_ready).
- Input transfer: inN_valid & inN_ready at a rising edge → hold_dN <= inN_data, hold_vN <= 1.
- Output slot free when ~out_valid | out_ready.
- Grant (combinational): only hold_v0 → 0; only hold_v1 → 1; both → ~last; neither → no grant, sel = last.
- Load: slot free & any hold_v → out_data <= hold_d[sel], out_src <= sel, out_valid <= 1, last <= sel, hold_v[sel] <= 0.
- Slot free, no hold_v: out_valid <= 0 (out_data, out_src retain value).
- out_valid & ~out_ready: out_data, out_src, out_valid stable; no load; holding registers keep filling.
- Simultaneous: hold_vN cleared by load and inN_ready low same cycle → no refill that edge; refill on following edge. Non-granted channel unaffected.
- Fairness: both channels continuously full → out_src alternates 0,1,0,1…; no channel waits more than one grant.

## Timing
- Reset (async assert, sync-to-clk deassert by upstream): hold_v0 = hold_v1 = 0, out_valid = 0, out_data = 0, out_src = 0, last = 1 (channel 0 wins first tie), in0_ready = in1_ready = 1, sel = 1.
- Latency: input accepted at edge k → out_valid high after edge k+1 (2 cycles minimum).
- Throughput: 1 word/cycle aggregate with both channels active; 1 word per 2 cycles per single channel.
- Reset mid-operation: all buffered words discarded, outputs to reset values immediately, no partial word emitted.
- Upstream must hold inN_data stable while inN_valid & ~inN_ready; block never drops or duplicates a word.

## Structure
- Shared package: WIDTH default, channel index type (1 bit), reset value of last pointer.
- Sub-module: mux2_w (WIDTH-wide 2:1 mux, out = sel ? in1 : in0) selects hold_d0/hold_d1; arbitration and registers in the top.
- Bench must check every output on every cycle against a reference model queue per channel.

## Test plan
- Reset then idle, out_ready = 1 → out_valid = 0, in0_ready = in1_ready = 1, out_data = 0 for 10 cycles.
- Single word: in0 = 8'hA5 valid one cycle → out_valid one cycle, two edges later, out_data = A5, out_src = 0.
- Both channels constant valid (in0 = 8'h11, in1 = 8'h22), out_ready = 1 → out stream 11,22,11,22…, out_src 0,1,0,1, first word from channel 0.
- Backpressure: out_ready = 0 for 5 cycles with both channels loaded → out_data/out_src frozen, in0_ready = in1_ready = 0; release → 3 words drained in order, none lost or duplicated.
- Single channel stream in1 = 1,2,3,4 back-to-back valid → in1_ready toggles 1,0,1,0; outputs 1,2,3,4 with out_src = 1.
- Async reset asserted mid-transfer with both holds full → outputs at reset values before next clock edge; after release, first new word on in1 = 8'h7E emerges alone with out_src = 1.

Source files
------------

// File: rtl/rr_mux2_stream_pkg.sv
// Shared types and constants for the two-channel round-robin stream arbiter.
// Also holds the grant function used by the top.
package rr_mux2_stream_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

  typedef logic chan_t;

  // Channel 1 marked as last served, so channel 0 wins the first tie
  localparam chan_t LAST_RST = 1'b1;

  // Round-robin pick; with nothing pending the select stays on the last winner
  function automatic chan_t rr_grant(input logic v0, input logic v1, input chan_t last);
    chan_t g;
    g = last;
    if (v0 && v1) begin
      g = ~last;
    end else if (v0) begin
      g = chan_t'(CH0);
    end else if (v1) begin
      g = chan_t'(CH1);
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_mux2_stream_mux2_w.sv
// WIDTH-wide 2:1 data mux; sel_i = 1 selects in1_i.
module mux2_w #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/rr_mux2_stream.sv
// Two-channel round-robin stream arbiter: one holding register per input,
// fair grant driving the 2:1 mux select, registered source-tagged output.
module rr_mux2_stream
  import rr_mux2_stream_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic             sel
);

  logic             hold_v0_q, hold_v0_d;
  logic             hold_v1_q, hold_v1_d;
  logic [WIDTH-1:0] hold_d0_q, hold_d0_d;
  logic [WIDTH-1:0] hold_d1_q, hold_d1_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  chan_t            out_src_q, out_src_d;
  chan_t            last_q, last_d;

  chan_t            grant_c;
  logic [WIDTH-1:0] mux_data_c;
  logic             slot_free_c;
  logic             load_c;
  logic             take0_c;
  logic             take1_c;

  assign grant_c     = rr_grant(hold_v0_q, hold_v1_q, last_q);
  assign slot_free_c = ~out_valid_q | out_ready;
  assign load_c      = slot_free_c & (hold_v0_q | hold_v1_q);
  // Ready comes from registered state only, so out_ready never reaches inN_ready
  assign take0_c     = in0_valid & ~hold_v0_q;
  assign take1_c     = in1_valid & ~hold_v1_q;

  mux2_w #(
    .WIDTH (WIDTH)
  ) u_mux (
    .in0_i (hold_d0_q),
    .in1_i (hold_d1_q),
    .sel_i (grant_c),
    .out_o (mux_data_c)
  );

  // Next-state: output slot load/drain, then holding register clear/fill
  always_comb begin
    hold_v0_d   = hold_v0_q;
    hold_v1_d   = hold_v1_q;
    hold_d0_d   = hold_d0_q;
    hold_d1_d   = hold_d1_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    last_d      = last_q;

    if (load_c) begin
      out_data_d  = mux_data_c;
      out_src_d   = grant_c;
      out_valid_d = 1'b1;
      last_d      = grant_c;
      if (grant_c == chan_t'(CH1)) begin
        hold_v1_d = 1'b0;
      end else begin
        hold_v0_d = 1'b0;
      end
    end else if (slot_free_c) begin
      out_valid_d = 1'b0;
    end

    // A channel emptied by this load had ready low, so take and clear never collide
    if (take0_c) begin
      hold_v0_d = 1'b1;
      hold_d0_d = in0_data;
    end
    if (take1_c) begin
      hold_v1_d = 1'b1;
      hold_d1_d = in1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v0_q   <= 1'b0;
      hold_v1_q   <= 1'b0;
      hold_d0_q   <= '0;
      hold_d1_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= chan_t'(CH0);
      last_q      <= LAST_RST;
    end else begin
      hold_v0_q   <= hold_v0_d;
      hold_v1_q   <= hold_v1_d;
      hold_d0_q   <= hold_d0_d;
      hold_d1_q   <= hold_d1_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      last_q      <= last_d;
    end
  end

  assign in0_ready = ~hold_v0_q;
  assign in1_ready = ~hold_v1_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign sel       = grant_c;

endmodule

// File: tb/tb_rr_mux2_stream.sv
// Directed bench for rr_mux2_stream with a per-channel queue model checked every cycle.
`timescale 1ns/1ps
module tb_rr_mux2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in0_data, in1_data;
  logic       in0_valid, in1_valid;
  logic       in0_ready, in1_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_src, sel;

  int n_tests = 0;
  int n_fail  = 0;

  rr_mux2_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one queue per channel (depth <= 1) plus output slot
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic       m_ov = 1'b0;
  logic [7:0] m_od = 8'h00;
  logic       m_os = 1'b0;
  logic       m_last = 1'b1;

  function automatic logic m_sel();
    if (mq0.size() != 0 && mq1.size() != 0) return ~m_last;
    if (mq0.size() != 0) return 1'b0;
    if (mq1.size() != 0) return 1'b1;
    return m_last;
  endfunction

  initial begin
    logic a0, a1, g;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq0.delete(); mq1.delete();
        m_ov = 1'b0; m_od = 8'h00; m_os = 1'b0; m_last = 1'b1;
      end else begin
        a0 = in0_valid && (mq0.size() == 0);
        a1 = in1_valid && (mq1.size() == 0);
        g  = m_sel();
        if (!m_ov || out_ready) begin
          if (mq0.size() != 0 || mq1.size() != 0) begin
            m_od   = g ? mq1.pop_front() : mq0.pop_front();
            m_os   = g;
            m_ov   = 1'b1;
            m_last = g;
          end else begin
            m_ov = 1'b0;
          end
        end
        if (a0) mq0.push_back(in0_data);
        if (a1) mq1.push_back(in1_data);
      end
    end
  end

  // Words actually handed downstream, logged from pre-edge DUT outputs
  logic [7:0] log_d[$];
  logic       log_s[$];
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && out_valid && out_ready) begin
        log_d.push_back(out_data);
        log_s.push_back(out_src);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cy_out_valid", 32'(out_valid), 32'(m_ov));
      check("cy_out_data",  32'(out_data),  32'(m_od));
      check("cy_out_src",   32'(out_src),   32'(m_os));
      check("cy_in0_ready", 32'(in0_ready), 32'(mq0.size() == 0));
      check("cy_in1_ready", 32'(in1_ready), 32'(mq1.size() == 0));
      check("cy_sel",       32'(sel),       32'(m_sel()));
    end
  end

  task automatic reset_dut();
    #1;
    rst_n = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    log_d.delete();
    log_s.delete();
  endtask

  logic [7:0] s_words [4];
  int         idx;
  logic       rdy;

  initial begin
    rst_n = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00;
    in0_valid = 1'b0; in1_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sel",       32'(sel),       32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_src",   32'(out_src),   32'd0);
    #1 rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_out_data",  32'(out_data),  32'd0);
      check("idle_in0_ready", 32'(in0_ready), 32'd1);
      check("idle_in1_ready", 32'(in1_ready), 32'd1);
    end

    // Single word on channel 0
    #1; in0_data = 8'hA5; in0_valid = 1'b1;
    @(negedge clk);
    check("sw_out_valid_early", 32'(out_valid), 32'd0);
    check("sw_in0_ready",       32'(in0_ready), 32'd0);
    #1 in0_valid = 1'b0;
    @(negedge clk);
    check("sw_out_valid", 32'(out_valid), 32'd1);
    check("sw_out_data",  32'(out_data),  32'hA5);
    check("sw_out_src",   32'(out_src),   32'd0);
    @(negedge clk);
    check("sw_out_valid_done", 32'(out_valid), 32'd0);

    // Both channels continuously valid: 11,22 alternating from channel 0
    reset_dut();
    in0_data = 8'h11; in0_valid = 1'b1;
    in1_data = 8'h22; in1_valid = 1'b1;
    repeat (10) @(negedge clk);
    #1; in0_valid = 1'b0; in1_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("alt_count", 32'(log_d.size()), 32'd10);
    for (int i = 0; i < log_d.size(); i++) begin
      check("alt_src",  32'(log_s[i]), 32'(i % 2));
      check("alt_data", 32'(log_d[i]), (i % 2 == 0) ? 32'h11 : 32'h22);
    end

    // Backpressure with both holds loaded
    reset_dut();
    out_ready = 1'b0;
    in0_data = 8'h31; in0_valid = 1'b1;
    in1_data = 8'h32; in1_valid = 1'b1;
    @(negedge clk);
    #1; in0_data = 8'h33; in1_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 in0_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'h31);
      check("bp_out_src",   32'(out_src),   32'd0);
      check("bp_in0_ready", 32'(in0_ready), 32'd0);
      check("bp_in1_ready", 32'(in1_ready), 32'd0);
    end
    #1 out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("bp_count", 32'(log_d.size()), 32'd3);
    if (log_d.size() == 3) begin
      check("bp_d0", 32'(log_d[0]), 32'h31); check("bp_s0", 32'(log_s[0]), 32'd0);
      check("bp_d1", 32'(log_d[1]), 32'h32); check("bp_s1", 32'(log_s[1]), 32'd1);
      check("bp_d2", 32'(log_d[2]), 32'h33); check("bp_s2", 32'(log_s[2]), 32'd0);
    end

    // Single channel stream on in1: 1,2,3,4
    reset_dut();
    s_words[0] = 8'h01; s_words[1] = 8'h02; s_words[2] = 8'h03; s_words[3] = 8'h04;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      in1_valid = (idx < 4);
      in1_data  = (idx < 4) ? s_words[idx] : 8'h00;
      check("s1_in1_ready", 32'(in1_ready), 32'((i % 2) == 0));
      rdy = in1_ready;
      @(negedge clk);
      if (rdy && in1_valid) idx++;
      #1;
    end
    in1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("s1_sent", 32'(idx), 32'd4);
    check("s1_count", 32'(log_d.size()), 32'd4);
    for (int i = 0; i < log_d.size(); i++) begin
      check("s1_data", 32'(log_d[i]), 32'(i + 1));
      check("s1_src",  32'(log_s[i]), 32'd1);
    end

    // Async reset with both holds full and output stalled
    reset_dut();
    out_ready = 1'b0;
    in0_data = 8'h44; in0_valid = 1'b1;
    in1_data = 8'h55; in1_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_pre_out_valid", 32'(out_valid), 32'd1);
    check("ar_pre_in0_ready", 32'(in0_ready), 32'd0);
    check("ar_pre_in1_ready", 32'(in1_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data",  32'(out_data),  32'd0);
    check("ar_out_src",   32'(out_src),   32'd0);
    check("ar_in0_ready", 32'(in0_ready), 32'd1);
    check("ar_in1_ready", 32'(in1_ready), 32'd1);
    check("ar_sel",       32'(sel),       32'd1);
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    log_d.delete(); log_s.delete();
    out_ready = 1'b1;
    in1_data = 8'h7E; in1_valid = 1'b1;
    @(negedge clk);
    #1 in1_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("ar_count", 32'(log_d.size()), 32'd1);
    if (log_d.size() == 1) begin
      check("ar_data", 32'(log_d[0]), 32'h7E);
      check("ar_src",  32'(log_s[0]), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
